// File: rtl/wb_copy_if.sv
// Bundle of the copy-command and Wishbone classic signals for wb_copy_master.
// Signal names are given from the master's point of view.
interface wb_copy_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned LW = 16
);
    logic          start_i;
    logic [AW-1:0] src_i;
    logic [AW-1:0] dst_i;
    logic [LW-1:0] len_i;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic          cyc_o;
    logic          stb_o;
    logic          we_o;
    logic [AW-1:0] adr_o;
    logic [3:0]    sel_o;
    logic [31:0]   dat_o;
    logic [31:0]   dat_i;
    logic          ack_i;

    modport master (
        input  start_i, src_i, dst_i, len_i, dat_i, ack_i,
        output busy_o, done_o, err_o, cyc_o, stb_o, we_o, adr_o, sel_o, dat_o
    );

    modport slave (
        output start_i, src_i, dst_i, len_i, dat_i, ack_i,
        input  busy_o, done_o, err_o, cyc_o, stb_o, we_o, adr_o, sel_o, dat_o
    );
endinterface

// File: rtl/wb_copy_master.sv
// Wishbone classic master that copies len 32-bit words from src to dst,
// one read then one write per word, with a per-transfer ack timeout.
module wb_copy_master #(
    parameter int unsigned AW      = 32,
    parameter int unsigned LW      = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    wb_copy_if.master   bus
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [31:0]   buf_q, buf_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          cyc_q, cyc_d;
    logic          stb_q, stb_d;
    logic          we_q, we_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   dat_q, dat_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ack_ok;
    logic          tmo_hit;
    logic          xfer;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= 4'h0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Acks only count while our own request is on the bus, so a lingering
    // ack during the one-cycle gap after each transfer is never taken twice.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        buf_d   = buf_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        ack_ok  = cyc_q && stb_q && bus.ack_i;
        tmo_hit = cyc_q && !ack_ok && (tmo_q == TW'(TIMEOUT - 1));

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    src_d   = bus.src_i;
                    dst_d   = bus.dst_i;
                    rem_d   = bus.len_i;
                    err_d   = 1'b0;
                    tmo_d   = '0;
                    state_d = (bus.len_i == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                if (ack_ok) begin
                    buf_d   = bus.dat_i;
                    tmo_d   = '0;
                    state_d = S_WR;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = S_DONE;
                end else if (cyc_q) begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WR: begin
                if (ack_ok) begin
                    src_d   = src_q + AW'(4);
                    dst_d   = dst_q + AW'(4);
                    rem_d   = rem_q - LW'(1);
                    tmo_d   = '0;
                    state_d = (rem_q == LW'(1)) ? S_DONE : S_RD;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = S_DONE;
                end else if (cyc_q) begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs follow the next state; an accepted ack forces the gap cycle.
        xfer   = (state_d == S_RD) || (state_d == S_WR);
        cyc_d  = xfer && !ack_ok;
        stb_d  = cyc_d;
        we_d   = cyc_d && (state_d == S_WR);
        adr_d  = !cyc_d ? '0 : ((state_d == S_WR) ? dst_d : src_d);
        sel_d  = cyc_d ? 4'hF : 4'h0;
        dat_d  = we_d ? buf_d : 32'h0;
        busy_d = xfer;
        done_d = (state_d == S_DONE);
    end

    always_comb begin
        bus.cyc_o  = cyc_q;
        bus.stb_o  = stb_q;
        bus.we_o   = we_q;
        bus.adr_o  = adr_q;
        bus.sel_o  = sel_q;
        bus.dat_o  = dat_q;
        bus.busy_o = busy_q;
        bus.done_o = done_q;
        bus.err_o  = err_q;
    end
endmodule
